mac_array_ws: RTL

MAC_ARRAY_WS -- requirements
Module: mac_array_ws

---
 rtl/mac_array_ws.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mac_array_ws.sv
// Weight-stationary MAC array. Instructions enter skewed down the west edge and then travel
// east, partial sums flow from north to south, and results leave row row-1 one column per cycle.
module mac_array_ws #(
    parameter int unsigned bw              = 4,
    parameter int unsigned psum_bw         = 16,
    parameter int unsigned row             = 8,
    parameter int unsigned col             = 8,
    parameter int unsigned channels_per_pe = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [row*channels_per_pe*bw-1:0] in_w,
    input  logic [2:0]                        inst_w,
    input  logic [psum_bw*col-1:0]            in_n,
    output logic [psum_bw*col-1:0]            out_s,
    output logic [col-1:0]                    valid,
    output logic                              busy
);
    localparam int unsigned AW = channels_per_pe * bw;

    logic [2:0]         r_skew   [row];
    logic [2:0]         w_inst_q [row][col];
    logic [AW-1:0]      w_act_q  [row][col];
    logic [psum_bw-1:0] w_psum_q [row][col];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < row; r++) r_skew[r] <= '0;
        end else begin
            r_skew[0] <= inst_w;
            for (int r = 1; r < row; r++) r_skew[r] <= r_skew[r-1];
        end
    end

    for (genvar gr = 0; gr < row; gr++) begin : g_row
        for (genvar gc = 0; gc < col; gc++) begin : g_col
            logic [2:0]         w_inst_in;
            logic [AW-1:0]      w_west;
            logic [psum_bw-1:0] w_north;
            logic [psum_bw-1:0] w_sum;
            logic               w_clr;
            logic               w_ld;
            logic               w_ex;
            logic [2:0]         r_inst;
            logic [AW-1:0]      r_wt;
            logic [AW-1:0]      r_act;
            logic               r_loaded;
            logic [psum_bw-1:0] r_psum;

            if (gc == 0) begin : g_west_edge
                assign w_inst_in = r_skew[gr];
                assign w_west    = in_w[gr*AW +: AW];
            end else begin : g_west_pe
                assign w_inst_in = w_inst_q[gr][gc-1];
                assign w_west    = w_act_q[gr][gc-1];
            end

            if (gr == 0) begin : g_north_edge
                assign w_north = in_n[gc*psum_bw +: psum_bw];
            end else begin : g_north_pe
                assign w_north = w_psum_q[gr-1][gc];
            end

            // Unsigned activation times signed weight, both widened to psum_bw before multiply.
            always_comb begin
                logic signed [psum_bw-1:0] w_a;
                logic signed [psum_bw-1:0] w_b;
                w_a   = '0;
                w_b   = '0;
                w_sum = w_north;
                for (int ch = 0; ch < channels_per_pe; ch++) begin
                    w_a   = psum_bw'($signed({1'b0, w_west[ch*bw +: bw]}));
                    w_b   = psum_bw'($signed(r_wt[ch*bw +: bw]));
                    w_sum = w_sum + $unsigned(w_a * w_b);
                end
            end

            assign w_clr = w_inst_in[2];
            assign w_ld  = !w_inst_in[2] && w_inst_in[0];
            assign w_ex  = !w_inst_in[2] && !w_inst_in[0] && w_inst_in[1];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_inst   <= '0;
                    r_wt     <= '0;
                    r_act    <= '0;
                    r_loaded <= 1'b0;
                    r_psum   <= '0;
                end else begin
                    r_inst <= w_inst_in;
                    if (w_clr) begin
                        r_wt     <= '0;
                        r_loaded <= 1'b0;
                    end else if (w_ld) begin
                        if (r_loaded) begin
                            r_act <= w_west;
                        end else begin
                            // A captured load word is consumed here, so the load stops too.
                            r_wt     <= w_west;
                            r_loaded <= 1'b1;
                            r_inst   <= '0;
                        end
                    end else if (w_ex) begin
                        r_act  <= w_west;
                        r_psum <= w_sum;
                    end
                end
            end

            assign w_inst_q[gr][gc] = r_inst;
            assign w_act_q[gr][gc]  = r_act;
            assign w_psum_q[gr][gc] = r_psum;
        end
    end

    for (genvar gc = 0; gc < col; gc++) begin : g_out
        assign out_s[gc*psum_bw +: psum_bw] = w_psum_q[row-1][gc];
        assign valid[gc] = !w_inst_q[row-1][gc][2] && !w_inst_q[row-1][gc][0] &&
                           w_inst_q[row-1][gc][1];
    end

    always_comb begin
        busy = 1'b0;
        for (int r = 0; r < row; r++) begin
            busy = busy | (|r_skew[r]);
            for (int c = 0; c < col; c++) busy = busy | (|w_inst_q[r][c]);
        end
    end

endmodule
